// File: rtl/pic_cascade_master.sv
// Master-side cascade / INTA sequencer for an 8259A-compatible PIC.
// Runs the two-pulse 8086 acknowledge sequence. It drives the slave ID on CAS
// when the acknowledged IR has a slave attached. Otherwise it drives the
// vector byte itself during the second INTA pulse.
module pic_cascade_master #(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inta_n,
    input  logic             int_req,
    input  logic [2:0]       int_level,
    input  logic             sp_en_n,
    input  logic             cascade_en,
    input  logic [7:0]       slave_mask,
    input  logic [4:0]       vector_base,
    output logic [2:0]       cas,
    output logic             cas_oe,
    output logic [VEC_W-1:0] data_out,
    output logic             data_oe,
    output logic             isr_set,
    output logic [2:0]       isr_level,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2
    } state_t;

    state_t           state_q, state_d;
    logic             inta_q, inta_d;
    logic             armed_q, armed_d;
    logic             to_slave_q, to_slave_d;
    logic [2:0]       isr_level_q, isr_level_d;
    logic [2:0]       cas_q, cas_d;
    logic             cas_oe_q, cas_oe_d;
    logic [VEC_W-1:0] data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic             isr_set_c;

    logic             act;
    logic             fall;
    logic             rise;
    logic [2:0]       lvl;
    logic [7:0]       vec8;
    logic [VEC_W-1:0] vec_w;

    // The vector byte is {T7..T3, level}. It is widened or truncated to
    // VEC_W, and any extra upper bits are zero.
    assign vec8 = {vector_base, isr_level_q};

    genvar gi;
    generate
        for (gi = 0; gi < VEC_W; gi++) begin : g_vec
            if (gi < 8) begin : g_bit
                assign vec_w[gi] = vec8[gi];
            end else begin : g_pad
                assign vec_w[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state and edge logic. armed_q blocks a "fall" until inta_n has been
    // seen high after reset. This prevents a phantom acknowledge when INTA is
    // already low at reset release.
    always_comb begin
        state_d     = state_q;
        inta_d      = inta_n;
        armed_d     = armed_q | inta_n;
        to_slave_d  = to_slave_q;
        isr_level_d = isr_level_q;
        cas_d       = cas_q;
        data_out_d  = '0;
        data_oe_d   = 1'b0;
        isr_set_c   = 1'b0;

        act      = sp_en_n & cascade_en;
        cas_oe_d = act;
        fall     = armed_q & inta_q & ~inta_n;
        rise     = ~inta_q & inta_n;
        lvl      = int_req ? int_level : 3'd7;

        if (!sp_en_n) begin
            // Slave role: the block is inert. Leaving master role mid-sequence
            // drops everything back to the idle picture.
            state_d     = IDLE;
            to_slave_d  = 1'b0;
            isr_level_d = 3'd0;
            cas_d       = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cas_d = 3'd0;
                    if (fall) begin
                        isr_level_d = lvl;
                        to_slave_d  = act & slave_mask[lvl];
                        cas_d       = (act & slave_mask[lvl]) ? lvl : 3'd0;
                        isr_set_c   = 1'b1;
                        state_d     = ACK1;
                    end
                end
                ACK1: begin
                    if (rise) begin
                        state_d = GAP;
                    end
                end
                GAP: begin
                    // The wait for the second INTA has no timeout.
                    if (fall) begin
                        state_d = ACK2;
                        if (!to_slave_q) begin
                            data_oe_d  = 1'b1;
                            data_out_d = vec_w;
                        end
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state_d = IDLE;
                        cas_d   = 3'd0;
                    end else if (!to_slave_q && !inta_n) begin
                        data_oe_d  = 1'b1;
                        data_out_d = vec_w;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cas_d   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inta_q      <= 1'b1;
            armed_q     <= 1'b0;
            to_slave_q  <= 1'b0;
            isr_level_q <= 3'd0;
            cas_q       <= 3'd0;
            cas_oe_q    <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_q      <= inta_d;
            armed_q     <= armed_d;
            to_slave_q  <= to_slave_d;
            isr_level_q <= isr_level_d;
            cas_q       <= cas_d;
            cas_oe_q    <= cas_oe_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    // isr_set and isr_level must be valid in the same cycle the first fall is
    // detected, so they bypass the registers while that fall is seen.
    assign isr_set   = isr_set_c & ~rst;
    assign isr_level = isr_set ? isr_level_d : isr_level_q;
    assign cas       = cas_q;
    assign cas_oe    = cas_oe_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pic_cascade_master.sv
// Directed bench for pic_cascade_master: INTA pulse pairs under several
// cascade configurations. Outputs are sampled 2 time units after each edge.
module tb_pic_cascade_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       inta_n;
    logic       int_req;
    logic [2:0] int_level;
    logic       sp_en_n;
    logic       cascade_en;
    logic [7:0] slave_mask;
    logic [4:0] vector_base;
    logic [2:0] cas;
    logic       cas_oe;
    logic [7:0] data_out;
    logic       data_oe;
    logic       isr_set;
    logic [2:0] isr_level;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Per-sequence observations gathered by run_inta.
    int         n_isr, n_cas_nz, n_cas_bad, n_doe, n_dout_bad, n_casoe_bad;
    logic [2:0] lvl_seen;
    logic [2:0] exp_cas;
    logic       exp_cas_oe;
    logic [7:0] exp_dout;

    pic_cascade_master #(.VEC_W(8)) dut (
        .clk(clk), .rst(rst), .inta_n(inta_n), .int_req(int_req),
        .int_level(int_level), .sp_en_n(sp_en_n), .cascade_en(cascade_en),
        .slave_mask(slave_mask), .vector_base(vector_base), .cas(cas),
        .cas_oe(cas_oe), .data_out(data_out), .data_oe(data_oe),
        .isr_set(isr_set), .isr_level(isr_level), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives INTA low for l1 cycles, high for g, and low for l2, then idles
    // high. Each cycle it records what the DUT shows. If chg is set, the
    // level and mask change early in the gap.
    task automatic run_inta(input int l1, input int g, input int l2, input bit chg);
        n_isr = 0; n_cas_nz = 0; n_cas_bad = 0; n_doe = 0; n_dout_bad = 0;
        n_casoe_bad = 0; lvl_seen = 3'd0;
        inta_n = 1'b1;
        tick(); tick();
        for (int i = 0; i < l1 + g + l2 + 3; i++) begin
            tick();
            inta_n = (i < l1) ? 1'b0 : (i < l1 + g) ? 1'b1 :
                     (i < l1 + g + l2) ? 1'b0 : 1'b1;
            if (chg && i == l1 + 1) begin
                int_level  = 3'd6;
                slave_mask = 8'h40;
            end
            #1;
            if (isr_set) begin n_isr++; lvl_seen = isr_level; end
            if (cas !== 3'd0) begin
                n_cas_nz++;
                if (cas !== exp_cas) n_cas_bad++;
            end
            if (cas_oe !== exp_cas_oe) n_casoe_bad++;
            if (data_oe) begin
                n_doe++;
                if (data_out !== exp_dout) n_dout_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inta_n = 1'b1; int_req = 1'b0; int_level = 3'd0;
        sp_en_n = 1'b1; cascade_en = 1'b1; slave_mask = 8'h00; vector_base = 5'd0;
        tick(); tick(); #1;
        vec_cnt++; if (cas !== 3'd0) begin err_cnt++; $display("FAIL reset_cas got %0d want 0", cas); end
        vec_cnt++; if (cas_oe !== 1'b0) begin err_cnt++; $display("FAIL reset_cas_oe got %0b want 0", cas_oe); end
        vec_cnt++; if (data_out !== 8'h00) begin err_cnt++; $display("FAIL reset_data_out got %h want 00", data_out); end
        vec_cnt++; if (data_oe !== 1'b0) begin err_cnt++; $display("FAIL reset_data_oe got %0b want 0", data_oe); end
        vec_cnt++; if (isr_set !== 1'b0) begin err_cnt++; $display("FAIL reset_isr_set got %0b want 0", isr_set); end
        vec_cnt++; if (isr_level !== 3'd0) begin err_cnt++; $display("FAIL reset_isr_level got %0d want 0", isr_level); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0b want 0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_slave_ack();
        slave_mask = 8'h04; int_req = 1'b1; int_level = 3'd2; vector_base = 5'b01000;
        exp_cas = 3'd2; exp_cas_oe = 1'b1; exp_dout = 8'h42;
        run_inta(2, 3, 2, 1'b0);
        vec_cnt++; if (n_isr !== 1) begin err_cnt++; $display("FAIL slave_isr_count got %0d want 1", n_isr); end
        vec_cnt++; if (lvl_seen !== 3'd2) begin err_cnt++; $display("FAIL slave_isr_level got %0d want 2", lvl_seen); end
        vec_cnt++; if (n_cas_nz !== 7) begin err_cnt++; $display("FAIL slave_cas_cycles got %0d want 7", n_cas_nz); end
        vec_cnt++; if (n_cas_bad !== 0) begin err_cnt++; $display("FAIL slave_cas_value got %0d bad want 0", n_cas_bad); end
        vec_cnt++; if (n_doe !== 0) begin err_cnt++; $display("FAIL slave_data_oe got %0d cycles want 0", n_doe); end
        vec_cnt++; if (n_casoe_bad !== 0) begin err_cnt++; $display("FAIL slave_cas_oe got %0d bad want 0", n_casoe_bad); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL slave_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_master_vector();
        slave_mask = 8'h04; int_req = 1'b1; int_level = 3'd5; vector_base = 5'b01000;
        exp_cas = 3'd0; exp_cas_oe = 1'b1; exp_dout = 8'h45;
        run_inta(2, 3, 3, 1'b0);
        vec_cnt++; if (n_isr !== 1) begin err_cnt++; $display("FAIL vec_isr_count got %0d want 1", n_isr); end
        vec_cnt++; if (lvl_seen !== 3'd5) begin err_cnt++; $display("FAIL vec_isr_level got %0d want 5", lvl_seen); end
        vec_cnt++; if (n_cas_nz !== 0) begin err_cnt++; $display("FAIL vec_cas_cycles got %0d want 0", n_cas_nz); end
        vec_cnt++; if (n_doe !== 3) begin err_cnt++; $display("FAIL vec_data_oe got %0d cycles want 3", n_doe); end
        vec_cnt++; if (n_dout_bad !== 0) begin err_cnt++; $display("FAIL vec_data_out got %0d bad want 0 (expect 45)", n_dout_bad); end
    endtask

    task automatic test_spurious();
        slave_mask = 8'h00; int_req = 1'b0; int_level = 3'd1; vector_base = 5'b01000;
        exp_cas = 3'd0; exp_cas_oe = 1'b1; exp_dout = 8'h47;
        run_inta(2, 2, 2, 1'b0);
        vec_cnt++; if (lvl_seen !== 3'd7) begin err_cnt++; $display("FAIL spur_isr_level got %0d want 7", lvl_seen); end
        vec_cnt++; if (n_doe !== 2) begin err_cnt++; $display("FAIL spur_data_oe got %0d cycles want 2", n_doe); end
        vec_cnt++; if (n_dout_bad !== 0) begin err_cnt++; $display("FAIL spur_data_out got %0d bad want 0 (expect 47)", n_dout_bad); end
    endtask

    task automatic test_latch_hold();
        slave_mask = 8'h08; int_req = 1'b1; int_level = 3'd3; vector_base = 5'b01000;
        exp_cas = 3'd3; exp_cas_oe = 1'b1; exp_dout = 8'h43;
        run_inta(2, 3, 2, 1'b1);
        vec_cnt++; if (lvl_seen !== 3'd3) begin err_cnt++; $display("FAIL hold_isr_level got %0d want 3", lvl_seen); end
        vec_cnt++; if (n_cas_nz !== 7) begin err_cnt++; $display("FAIL hold_cas_cycles got %0d want 7", n_cas_nz); end
        vec_cnt++; if (n_cas_bad !== 0) begin err_cnt++; $display("FAIL hold_cas_value got %0d bad want 0", n_cas_bad); end
        vec_cnt++; if (n_doe !== 0) begin err_cnt++; $display("FAIL hold_data_oe got %0d cycles want 0", n_doe); end
    endtask

    task automatic test_reset_in_gap();
        slave_mask = 8'h08; int_req = 1'b1; int_level = 3'd3;
        inta_n = 1'b1; tick(); tick();
        inta_n = 1'b0; tick(); tick();
        inta_n = 1'b1; tick(); tick();
        vec_cnt++; if (cas !== 3'd3) begin err_cnt++; $display("FAIL gap_cas got %0d want 3", cas); end
        rst = 1'b1; tick(); #1;
        vec_cnt++; if (cas !== 3'd0) begin err_cnt++; $display("FAIL gap_rst_cas got %0d want 0", cas); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL gap_rst_busy got %0b want 0", busy); end
        rst = 1'b0;
        exp_cas = 3'd3; exp_cas_oe = 1'b1; exp_dout = 8'h43;
        run_inta(2, 2, 2, 1'b0);
        vec_cnt++; if (n_isr !== 1) begin err_cnt++; $display("FAIL gap_fresh_isr got %0d want 1", n_isr); end
        vec_cnt++; if (n_cas_nz !== 6) begin err_cnt++; $display("FAIL gap_fresh_cas_cycles got %0d want 6", n_cas_nz); end
    endtask

    task automatic test_inta_low_at_reset();
        int n = 0;
        rst = 1'b1; inta_n = 1'b0; tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); #1; if (isr_set) n++; end
        vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL lowrst_isr got %0d want 0", n); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL lowrst_busy got %0b want 0", busy); end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; #1;
        vec_cnt++; if (isr_set !== 1'b1) begin err_cnt++; $display("FAIL lowrst_rearm got %0b want 1", isr_set); end
        rst = 1'b1; inta_n = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_slave_role_and_single();
        sp_en_n = 1'b0; cascade_en = 1'b1; slave_mask = 8'hFF; int_level = 3'd4;
        exp_cas = 3'd0; exp_cas_oe = 1'b0; exp_dout = 8'h00;
        run_inta(2, 2, 2, 1'b0);
        vec_cnt++; if (n_isr !== 0) begin err_cnt++; $display("FAIL slv_isr got %0d want 0", n_isr); end
        vec_cnt++; if (n_doe !== 0) begin err_cnt++; $display("FAIL slv_data_oe got %0d want 0", n_doe); end
        vec_cnt++; if (n_casoe_bad !== 0) begin err_cnt++; $display("FAIL slv_cas_oe got %0d bad want 0", n_casoe_bad); end
        sp_en_n = 1'b1; cascade_en = 1'b0; vector_base = 5'b10101;
        exp_dout = 8'hAC;
        run_inta(2, 2, 2, 1'b0);
        vec_cnt++; if (n_isr !== 1) begin err_cnt++; $display("FAIL single_isr got %0d want 1", n_isr); end
        vec_cnt++; if (n_cas_nz !== 0) begin err_cnt++; $display("FAIL single_cas got %0d want 0", n_cas_nz); end
        vec_cnt++; if (n_casoe_bad !== 0) begin err_cnt++; $display("FAIL single_cas_oe got %0d bad want 0", n_casoe_bad); end
        vec_cnt++; if (n_doe !== 2) begin err_cnt++; $display("FAIL single_data_oe got %0d want 2", n_doe); end
        vec_cnt++; if (n_dout_bad !== 0) begin err_cnt++; $display("FAIL single_data_out got %0d bad want 0 (expect AC)", n_dout_bad); end
    endtask

    task automatic test_abort();
        sp_en_n = 1'b1; cascade_en = 1'b1; slave_mask = 8'h02; int_req = 1'b1; int_level = 3'd1;
        inta_n = 1'b1; tick(); tick();
        inta_n = 1'b0; tick(); tick();
        inta_n = 1'b1; tick(); tick();
        sp_en_n = 1'b0; tick(); #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %0b want 0", busy); end
        vec_cnt++; if (cas !== 3'd0) begin err_cnt++; $display("FAIL abort_cas got %0d want 0", cas); end
        vec_cnt++; if (cas_oe !== 1'b0) begin err_cnt++; $display("FAIL abort_cas_oe got %0b want 0", cas_oe); end
        sp_en_n = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_slave_ack();
        test_master_vector();
        test_spurious();
        test_latch_hold();
        test_reset_in_gap();
        test_inta_low_at_reset();
        test_slave_role_and_single();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pic_cascade_master.md
Name: pic_cascade_master

Overview:
- Master-side cascade/INTA sequencer for the 8259A-compatible PIC.
- Runs the two-pulse 8086-mode interrupt-acknowledge sequence and drives the slave ID onto CAS[2:0] when the acknowledged IR input has a slave attached.
- When the IR has no slave, it drives the vector byte itself instead.
- It is the driving end of the cascade bus whose slave-side ID comparator already exists; it sits between the priority resolver/ISR logic and the external INTA_n/CAS/data pins.

Parameters:
- VEC_W, 8, width of the vector byte on data_out.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inta_n  input  1  interrupt acknowledge from CPU, active low, already synchronised to clk.
- int_req  input  1  priority resolver reports a pending, unmasked request.
- int_level  input  3  highest-priority pending IR number (0..7); valid when int_req=1.
- sp_en_n  input  1  1 = this device is master, 0 = slave (block inert).
- cascade_en  input  1  1 = cascade mode (ICW1 SNGL=0).
- slave_mask  input  8  ICW3 master image; bit n=1 means a slave is on IRn.
- vector_base  input  5  ICW2 T7..T3.
- cas  output  3  cascade ID bus value.
- cas_oe  output  1  CAS pin driver enable.
- data_out  output  VEC_W  vector byte.
- data_oe  output  1  data bus driver enable.
- isr_set  output  1  one-cycle pulse: set ISR bit isr_level.
- isr_level  output  3  level acknowledged; valid with isr_set and held until the next sequence.
- busy  output  1  acknowledge sequence in progress.

Behaviour:
- Reset values:
  - cas=000, cas_oe=0, data_out=0, data_oe=0, isr_set=0, isr_level=000, busy=0.
  - FSM=IDLE; internal inta_q=1.
- Edge detection on registered inta_q:
  - fall = inta_q & ~inta_n.
  - rise = ~inta_q & inta_n.
- Active condition: act = sp_en_n & cascade_en. When sp_en_n=0:
  - cas_oe=0, data_oe=0, isr_set=0.
  - FSM held in IDLE.
- cas_oe = act in every state, including IDLE.
- FSM states: IDLE, ACK1, GAP, ACK2.
  - IDLE: on fall (and sp_en_n=1):
    - lvl = int_req ? int_level : 3'd7 (spurious → IR7).
    - Latch lvl into isr_level.
    - Latch to_slave = act & slave_mask[lvl].
    - isr_set=1 for exactly this one cycle.
    - busy=1; go to ACK1.
  - ACK1: on rise → GAP.
  - GAP: on fall → ACK2.
  - ACK2:
    - If to_slave=0: data_oe=1 and data_out={vector_base, isr_level} for every cycle inta_n is low.
    - On rise: data_oe=0, cas=000, busy=0; go to IDLE.
- CAS drive:
  - cas = to_slave ? isr_level : 000 from the cycle after the first fall until the cycle after the second rise.
  - cas=000 at all other times.
- Single mode (cascade_en=0, sp_en_n=1):
  - Sequence still runs and the master supplies the vector.
  - cas_oe=0, cas=000.
- Latency:
  - isr_set is asserted in the cycle fall is detected.
  - cas and data_oe are valid one clk after the corresponding edge is detected.
- Boundary cases:
  - int_req, int_level and slave_mask changes after latching are ignored until IDLE.
  - inta_n low at reset release: no fall is detected until inta_n has gone high and then low again.
  - rst mid-sequence: all outputs return to their reset values the next cycle, FSM=IDLE, no isr_set.
  - sp_en_n falling to 0 mid-sequence aborts to IDLE as if reset.
  - No timeout: GAP waits indefinitely for the second INTA.

Test Plan:
- Master, cascade_en=1, slave_mask=8'h04, int_req=1, int_level=2, two INTA pulses → cas=010 from the first fall through the second rise; data_oe never 1; one isr_set pulse with isr_level=2.
- Same configuration, int_level=5 (no slave), vector_base=5'b01000 → cas=000; data_out=8'h45 with data_oe=1 only during the second INTA; isr_set once.
- int_req=0 at the first INTA fall, slave_mask=0 → isr_level=7, data_out={vector_base,3'b111} on the second INTA.
- int_level changed from 3 to 6 during GAP, slave_mask=8'h08 → cas remains 011 through the second INTA; isr_level=3.
- rst asserted in GAP after cas=011 → next cycle cas=000, busy=0, FSM IDLE; a fresh INTA pair completes normally.
- sp_en_n=0 with INTA pulses → cas_oe=0, data_oe=0, isr_set never asserted; cascade_en=0 with sp_en_n=1 and slave_mask=8'hFF → master supplies the vector, cas_oe=0.
